// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: pipeline stall levels,
// arbiter state encodings and the last-grant tracking constants.
package mem_bus_arbiter_pkg;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam int STALL_IF_BIT  = 1;
  localparam int STALL_MEM_BIT = 4;

  localparam logic [3:0] SEL_WORD = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_D = 2'd1,
    ST_GNT_I = 2'd2,
    ST_DRAIN = 2'd3
  } arb_state_t;

  typedef enum logic {
    LAST_GNT_INST = 1'b0,
    LAST_GNT_DATA = 1'b1
  } last_gnt_t;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the instruction-fetch and MEM-stage requesters onto one shared
// memory bus, alternating on contention and holding results across stalls.
//
// state    | meaning
// IDLE     | bus free, pick a winner from the pending requests
// GNT_D    | data transfer on the bus, waiting for bus_ack
// GNT_I    | fetch transfer on the bus, waiting for bus_ack
// DRAIN    | flushed fetch, wait for bus_ack and discard the data
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_done,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  input  logic [5:0]  stall,
  input  logic        flush,
  output logic        stallreq_if,
  output logic        stallreq_mem
);

  arb_state_t  state_q, state_d;
  last_gnt_t   last_gnt_q, last_gnt_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [3:0]  bus_sel_q, bus_sel_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        mem_done_q, mem_done_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic        if_done_q, if_done_d;

  logic data_pend, fetch_pend;
  logic take_data, take_inst;
  logic unused_stall;

  assign unused_stall = ^{stall[5], stall[3:2], stall[0]};

  assign data_pend  = mem_req & ~mem_done_q;
  assign fetch_pend = if_req & ~if_done_q & ~flush;

  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_sel_d   = bus_sel_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    mem_rdata_d = mem_rdata_q;
    mem_done_d  = mem_done_q;
    if_rdata_d  = if_rdata_q;
    if_done_d   = if_done_q;
    take_data   = 1'b0;
    take_inst   = 1'b0;

    // Completion flags persist only while the consuming stage is held.
    if (mem_done_q && ((stall[STALL_MEM_BIT] == NO_STOP) || flush)) mem_done_d = 1'b0;
    if (if_done_q && ((stall[STALL_IF_BIT] == NO_STOP) || flush))   if_done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (data_pend && fetch_pend && (last_gnt_q == LAST_GNT_DATA)) take_inst = 1'b1;
        else if (data_pend)                                            take_data = 1'b1;
        else if (fetch_pend)                                           take_inst = 1'b1;
      end
      ST_GNT_D: begin
        if (bus_ack) begin
          mem_rdata_d = bus_rdata;
          mem_done_d  = 1'b1;
          last_gnt_d  = LAST_GNT_DATA;
          bus_req_d   = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      ST_GNT_I: begin
        if (flush) begin
          // A flush racing the ack simply discards the returning word.
          if (bus_ack) begin
            bus_req_d = 1'b0;
            state_d   = ST_IDLE;
          end else begin
            state_d   = ST_DRAIN;
          end
        end else if (bus_ack) begin
          if_rdata_d = bus_rdata;
          if_done_d  = 1'b1;
          last_gnt_d = LAST_GNT_INST;
          bus_req_d  = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (bus_ack) begin
          bus_req_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (take_data) begin
      state_d     = ST_GNT_D;
      bus_req_d   = 1'b1;
      bus_we_d    = mem_we;
      bus_sel_d   = mem_sel;
      bus_addr_d  = mem_addr;
      bus_wdata_d = mem_wdata;
    end else if (take_inst) begin
      state_d     = ST_GNT_I;
      bus_req_d   = 1'b1;
      bus_we_d    = 1'b0;
      bus_sel_d   = SEL_WORD;
      bus_addr_d  = if_addr;
      bus_wdata_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      last_gnt_q  <= LAST_GNT_INST;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_sel_q   <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      mem_rdata_q <= '0;
      mem_done_q  <= 1'b0;
      if_rdata_q  <= '0;
      if_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_sel_q   <= bus_sel_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      mem_rdata_q <= mem_rdata_d;
      mem_done_q  <= mem_done_d;
      if_rdata_q  <= if_rdata_d;
      if_done_q   <= if_done_d;
    end
  end

  assign bus_req      = bus_req_q;
  assign bus_we       = bus_we_q;
  assign bus_sel      = bus_sel_q;
  assign bus_addr     = bus_addr_q;
  assign bus_wdata    = bus_wdata_q;
  assign mem_rdata    = mem_rdata_q;
  assign mem_done     = mem_done_q;
  assign if_rdata     = if_rdata_q;
  assign if_done      = if_done_q;
  assign stallreq_mem = mem_req & ~mem_done_q;
  assign stallreq_if  = if_req & ~if_done_q & ~flush;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scenario bench for mem_bus_arbiter: expected bus transactions are queued as
// requests are raised and compared when the arbiter puts them on the bus.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic        clk, rst;
  logic        if_req;
  logic [31:0] if_addr, if_rdata;
  logic        if_done;
  logic        mem_req, mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_done;
  logic        bus_req, bus_we;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic [5:0]  stall;
  logic        flush;
  logic        stallreq_if, stallreq_mem;

  int   n_cmp  = 0;
  int   n_fail = 0;
  txn_t exp_q[$];

  mem_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .bus_req(bus_req), .bus_we(bus_we), .bus_sel(bus_sel), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .stall(stall), .flush(flush),
    .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for a transfer, holds off the ack for lat cycles, then acks it.
  task automatic serve(input int lat, input logic [31:0] rdata, output txn_t obs);
    int w = 0;
    bit held = 1'b1;
    while (!bus_req && w < 20) begin step(); w++; end
    n_cmp++;
    if (!bus_req) begin
      n_fail++;
      $display("FAIL serve_grant: bus_req=%0b after %0d cycles, required 1", bus_req, w);
      obs = '0;
      return;
    end
    obs = {bus_we, bus_sel, bus_addr, bus_wdata};
    for (int i = 0; i < lat; i++) begin
      step();
      if (!bus_req || ({bus_we, bus_sel, bus_addr, bus_wdata} !== obs)) held = 1'b0;
    end
    n_cmp++;
    if (!held) begin
      n_fail++;
      $display("FAIL serve_hold: bus request not held until ack, required held");
    end
    bus_ack = 1'b1; bus_rdata = rdata;
    step();
    bus_ack = 1'b0; bus_rdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    n_cmp++;
    if ({bus_req, bus_we, bus_sel, bus_addr, bus_wdata, if_rdata, if_done,
         mem_rdata, mem_done, stallreq_if, stallreq_mem} !== '0 ||
        dut.state_q !== ST_IDLE || dut.last_gnt_q !== LAST_GNT_INST) begin
      n_fail++;
      $display("FAIL reset_state: bus_req=%0b bus_addr=%h if_done=%0b mem_done=%0b state=%0d, required all 0 / IDLE / INST",
               bus_req, bus_addr, if_done, mem_done, dut.state_q);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_fetch();
    txn_t obs, e;
    if_req = 1'b1; if_addr = 32'hBFC0_0000;
    exp_q.push_back('{we: 1'b0, sel: 4'hF, addr: 32'hBFC0_0000, wdata: 32'h0});
    #1;
    n_cmp++;
    if (stallreq_if !== 1'b1) begin n_fail++; $display("FAIL fetch_stallreq_pending: got %0b required 1", stallreq_if); end
    serve(3, 32'h2408_0001, obs);
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== e) begin n_fail++; $display("FAIL fetch_bus_txn: got %h required %h", obs, e); end
    n_cmp++;
    if (if_done !== 1'b1 || if_rdata !== 32'h2408_0001) begin
      n_fail++; $display("FAIL fetch_result: if_done=%0b if_rdata=%h required 1 / 24080001", if_done, if_rdata);
    end
    n_cmp++;
    if (stallreq_if !== 1'b0 || bus_req !== 1'b0) begin
      n_fail++; $display("FAIL fetch_release: stallreq_if=%0b bus_req=%0b required 0 / 0", stallreq_if, bus_req);
    end
    if_req = 1'b0;
    step();
    n_cmp++;
    if (if_done !== 1'b0) begin n_fail++; $display("FAIL fetch_done_clear: got %0b required 0", if_done); end
  endtask

  task automatic test_simultaneous();
    txn_t obs, e;
    for (int p = 0; p < 4; p++) begin
      mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF;
      mem_addr = 32'h8000_0100 + 32'(p * 4); mem_wdata = 32'h0000_1000 + 32'(p);
      if_req = 1'b1; if_addr = 32'hBFC0_0100 + 32'(p * 4);
      exp_q.push_back('{we: 1'b0, sel: 4'hF, addr: mem_addr, wdata: mem_wdata});
      exp_q.push_back('{we: 1'b0, sel: 4'hF, addr: if_addr, wdata: 32'h0});
      serve(1, 32'hD000_0000 + 32'(p), obs);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin n_fail++; $display("FAIL simul_data_first[%0d]: got %h required %h", p, obs, e); end
      n_cmp++;
      if (mem_done !== 1'b1 || mem_rdata !== 32'hD000_0000 + 32'(p)) begin
        n_fail++; $display("FAIL simul_data_result[%0d]: mem_done=%0b mem_rdata=%h", p, mem_done, mem_rdata);
      end
      mem_req = 1'b0;
      n_cmp++;
      if (bus_req !== 1'b0) begin n_fail++; $display("FAIL simul_idle_gap[%0d]: bus_req=%0b required 0", p, bus_req); end
      step();
      n_cmp++;
      if (bus_req !== 1'b1) begin n_fail++; $display("FAIL simul_next_grant[%0d]: bus_req=%0b required 1", p, bus_req); end
      serve(1, 32'hC000_0000 + 32'(p), obs);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin n_fail++; $display("FAIL simul_inst_second[%0d]: got %h required %h", p, obs, e); end
      n_cmp++;
      if (if_done !== 1'b1 || if_rdata !== 32'hC000_0000 + 32'(p)) begin
        n_fail++; $display("FAIL simul_inst_result[%0d]: if_done=%0b if_rdata=%h", p, if_done, if_rdata);
      end
      if_req = 1'b0;
      step();
    end
  endtask

  task automatic test_stalled_store();
    txn_t obs, e;
    int done_cycles = 0;
    int sreq_hits = 0;
    int extra_req = 0;
    mem_req = 1'b1; mem_we = 1'b1; mem_sel = 4'b0011;
    mem_addr = 32'h8000_1000; mem_wdata = 32'hDEAD_BEEF;
    exp_q.push_back('{we: 1'b1, sel: 4'b0011, addr: 32'h8000_1000, wdata: 32'hDEAD_BEEF});
    serve(2, 32'h0BAD_0BAD, obs);
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== e) begin n_fail++; $display("FAIL store_bus_txn: got %h required %h", obs, e); end
    stall = 6'b01_0000;
    for (int i = 0; i < 5; i++) begin
      if (mem_done && mem_rdata === 32'h0BAD_0BAD) done_cycles++;
      if (stallreq_mem) sreq_hits++;
      if (bus_req) extra_req++;
      step();
    end
    stall = 6'b0;
    step();
    mem_req = 1'b0;
    n_cmp++;
    if (mem_done !== 1'b0) begin n_fail++; $display("FAIL store_done_release: got %0b required 0", mem_done); end
    for (int i = 0; i < 3; i++) begin
      if (bus_req) extra_req++;
      step();
    end
    n_cmp++;
    if (done_cycles != 5) begin n_fail++; $display("FAIL store_done_hold: %0d cycles held, required 5", done_cycles); end
    n_cmp++;
    if (sreq_hits != 0) begin n_fail++; $display("FAIL store_stallreq: high %0d cycles, required 0", sreq_hits); end
    n_cmp++;
    if (extra_req != 0) begin n_fail++; $display("FAIL store_single_write: %0d extra bus cycles, required 0", extra_req); end
  endtask

  task automatic test_fairness();
    txn_t obs, e;
    mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hC; mem_addr = 32'h8000_3000; mem_wdata = 32'h0;
    if_req = 1'b1; if_addr = 32'hBFC0_0200;
    exp_q.push_back('{we: 1'b0, sel: 4'hF, addr: 32'hBFC0_0200, wdata: 32'h0});
    exp_q.push_back('{we: 1'b0, sel: 4'hC, addr: 32'h8000_3000, wdata: 32'h0});
    serve(1, 32'h1A1A_0001, obs);
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== e) begin n_fail++; $display("FAIL fair_inst_first: got %h required %h", obs, e); end
    if_req = 1'b0;
    serve(1, 32'h2B2B_0002, obs);
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== e) begin n_fail++; $display("FAIL fair_data_second: got %h required %h", obs, e); end
    n_cmp++;
    if (mem_rdata !== 32'h2B2B_0002) begin n_fail++; $display("FAIL fair_data_rdata: got %h required 2b2b0002", mem_rdata); end
    mem_req = 1'b0;
    step();
  endtask

  task automatic test_flush_fetch();
    txn_t obs, e;
    int w = 0;
    int held = 0;
    if_req = 1'b1; if_addr = 32'hBFC0_0300;
    exp_q.push_back('{we: 1'b0, sel: 4'hF, addr: 32'hBFC0_0300, wdata: 32'h0});
    while (!bus_req && w < 20) begin step(); w++; end
    n_cmp++;
    if (!bus_req) begin n_fail++; $display("FAIL flush_grant_timeout: bus_req=%0b required 1", bus_req); end
    obs = {bus_we, bus_sel, bus_addr, bus_wdata};
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== e) begin n_fail++; $display("FAIL flush_bus_txn: got %h required %h", obs, e); end
    flush = 1'b1;
    #1;
    n_cmp++;
    if (stallreq_if !== 1'b0) begin n_fail++; $display("FAIL flush_stallreq_if: got %0b required 0", stallreq_if); end
    step();
    n_cmp++;
    if (dut.state_q !== ST_DRAIN) begin n_fail++; $display("FAIL flush_drain_state: got %0d required %0d", dut.state_q, ST_DRAIN); end
    flush = 1'b0; if_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (bus_req && !if_done) held++;
      step();
    end
    bus_ack = 1'b1; bus_rdata = 32'h1111_1111;
    step();
    bus_ack = 1'b0; bus_rdata = '0;
    n_cmp++;
    if (held != 2) begin n_fail++; $display("FAIL flush_bus_held: %0d cycles, required 2", held); end
    n_cmp++;
    if (dut.state_q !== ST_IDLE || bus_req !== 1'b0 || if_done !== 1'b0 || if_rdata !== 32'h1A1A_0001) begin
      n_fail++;
      $display("FAIL flush_after_ack: state=%0d bus_req=%0b if_done=%0b if_rdata=%h required IDLE/0/0/1a1a0001",
               dut.state_q, bus_req, if_done, if_rdata);
    end
  endtask

  task automatic test_flush_data();
    txn_t obs, e;
    mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h8000_4000; mem_wdata = 32'h1234_5678;
    flush = 1'b1;
    exp_q.push_back('{we: 1'b0, sel: 4'hF, addr: 32'h8000_4000, wdata: 32'h1234_5678});
    serve(2, 32'h5A5A_5A5A, obs);
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== e) begin n_fail++; $display("FAIL flushdata_bus_txn: got %h required %h", obs, e); end
    n_cmp++;
    if (mem_done !== 1'b1 || mem_rdata !== 32'h5A5A_5A5A) begin
      n_fail++; $display("FAIL flushdata_complete: mem_done=%0b mem_rdata=%h required 1 / 5a5a5a5a", mem_done, mem_rdata);
    end
    flush = 1'b0; mem_req = 1'b0;
    step();
  endtask

  task automatic test_ack_idle();
    bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    step();
    bus_ack = 1'b0; bus_rdata = '0;
    n_cmp++;
    if ({bus_req, mem_done, if_done} !== 3'b000 || mem_rdata !== 32'h5A5A_5A5A || if_rdata !== 32'h1A1A_0001) begin
      n_fail++;
      $display("FAIL idle_ack_ignored: bus_req=%0b mem_done=%0b if_done=%0b mem_rdata=%h if_rdata=%h",
               bus_req, mem_done, if_done, mem_rdata, if_rdata);
    end
  endtask

  task automatic test_reset_mid();
    txn_t obs, e;
    int w = 0;
    mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h8000_2000; mem_wdata = 32'h0;
    exp_q.push_back('{we: 1'b0, sel: 4'hF, addr: 32'h8000_2000, wdata: 32'h0});
    while (!bus_req && w < 20) begin step(); w++; end
    obs = {bus_we, bus_sel, bus_addr, bus_wdata};
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== e || dut.state_q !== ST_GNT_D) begin
      n_fail++; $display("FAIL rstmid_grant: got %h state=%0d required %h / GNT_D", obs, dut.state_q, e);
    end
    rst = 1'b1; mem_req = 1'b0;
    step();
    n_cmp++;
    if ({bus_req, bus_we, bus_sel, bus_addr, bus_wdata, if_rdata, if_done, mem_rdata, mem_done} !== '0) begin
      n_fail++; $display("FAIL rstmid_outputs: bus_req=%0b bus_addr=%h mem_rdata=%h if_rdata=%h required all 0",
                         bus_req, bus_addr, mem_rdata, if_rdata);
    end
    rst = 1'b0;
    step();
    bus_ack = 1'b1; bus_rdata = 32'hDEAD_DEAD;
    step();
    bus_ack = 1'b0; bus_rdata = '0;
    n_cmp++;
    if (mem_done !== 1'b0 || mem_rdata !== 32'h0 || bus_req !== 1'b0 || dut.state_q !== ST_IDLE) begin
      n_fail++; $display("FAIL rstmid_late_ack: mem_done=%0b mem_rdata=%h bus_req=%0b required 0/0/0", mem_done, mem_rdata, bus_req);
    end
    mem_req = 1'b1; mem_addr = 32'h8000_2004;
    exp_q.push_back('{we: 1'b0, sel: 4'hF, addr: 32'h8000_2004, wdata: 32'h0});
    serve(1, 32'h600D_600D, obs);
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== e) begin n_fail++; $display("FAIL rstmid_next_txn: got %h required %h", obs, e); end
    n_cmp++;
    if (mem_done !== 1'b1 || mem_rdata !== 32'h600D_600D) begin
      n_fail++; $display("FAIL rstmid_next_result: mem_done=%0b mem_rdata=%h required 1 / 600d600d", mem_done, mem_rdata);
    end
    mem_req = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_sel = '0; mem_addr = '0; mem_wdata = '0;
    bus_ack = 1'b0; bus_rdata = '0; stall = '0; flush = 1'b0;
    test_reset();
    test_fetch();
    test_simultaneous();
    test_stalled_store();
    test_fairness();
    test_flush_fetch();
    test_flush_data();
    test_ack_idle();
    test_reset_mid();
    n_cmp++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: %0d left, required 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
